// File: rtl/act_loader_if.sv
// rtl/act_loader_if.sv - usram read port and 64-bit output stream bundle for act_loader
interface act_loader_if #(
    parameter int AW = 16
) ();
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic          out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_last,
        input  rd_rdata, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_last,
        output rd_rdata, out_ready
    );
endinterface

// File: rtl/act_loader.sv
// rtl/act_loader.sv - fetches NUM_WORDS 64-bit usram words after a CSR start edge and streams them out
module act_loader #(
    parameter int NUM_WORDS = 64,
    parameter int AW        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  start,
    input  logic [31:0]  input_base,
    output logic         busy,
    output logic         load_done,
    act_loader_if.master bus
);
    localparam int            CW       = 17;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic          start_nz;
    logic          start_q;
    logic          start_edge;
    logic [AW-1:0] base_q;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] out_cnt;
    logic          rd_en_q;
    logic          credit;
    logic          pop;
    logic          flush;
    logic [63:0]   fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    fifo_count;
    logic [2:0]    occ_after;
    logic          unused_base_hi;

    assign start_nz       = (start != 32'd0);
    assign start_edge     = start_nz & ~start_q;
    assign unused_base_hi = ^input_base[31:AW];

    // Occupancy after this cycle's write-back and pop; a new read may only
    // issue if its word will still have a slot when it lands next cycle.
    assign pop       = bus.out_valid & bus.out_ready;
    assign occ_after = {1'b0, fifo_count} + {2'b00, rd_en_q} - {2'b00, pop};
    assign credit    = (occ_after <= 3'd1);

    assign bus.rd_en     = (state == LOAD) & credit;
    assign bus.rd_addr   = base_q + issue_cnt[AW-1:0];
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.out_last  = bus.out_valid & (out_cnt == LAST_IDX);

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        load_done  = (state == DONE);
        case (state)
            IDLE: begin
                if (start_edge) state_next = LOAD;
            end
            LOAD: begin
                if (!start_nz)                                 state_next = IDLE;
                else if (bus.rd_en && (issue_cnt == LAST_IDX)) state_next = DRAIN;
            end
            DRAIN: begin
                if (!start_nz)                  state_next = IDLE;
                else if (pop && bus.out_last)   state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Any return to IDLE (abort or completion) empties the FIFO and drops
    // the read still in flight.
    assign flush = (state_next == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            base_q  <= '0;
        end else begin
            state   <= state_next;
            start_q <= start_nz;
            if ((state == IDLE) && start_edge) base_q <= input_base[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush || (state == IDLE)) begin
            issue_cnt  <= '0;
            out_cnt    <= '0;
            rd_en_q    <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            rd_en_q    <= bus.rd_en;
            issue_cnt  <= issue_cnt + CW'(bus.rd_en);
            out_cnt    <= out_cnt + CW'(pop);
            fifo_count <= occ_after[1:0];
            if (rd_en_q) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (rd_en_q && !flush) begin
            fifo_mem[wr_ptr] <= bus.rd_rdata;
        end
    end
endmodule

// File: tb/tb_act_loader.sv
// tb/tb_act_loader.sv - self-checking bench for act_loader with usram model and stream scoreboard
module tb_act_loader;
    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] start, input_base, start1, base1;
    logic        busy, load_done, busy1, load_done1;

    always #5 clk = ~clk;

    act_loader_if #(.AW(AW)) bus ();
    act_loader_if #(.AW(AW)) bus1 ();

    act_loader #(.NUM_WORDS(4), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .input_base(input_base),
        .busy(busy), .load_done(load_done), .bus(bus)
    );

    act_loader #(.NUM_WORDS(1), .AW(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .input_base(base1),
        .busy(busy1), .load_done(load_done1), .bus(bus1)
    );

    function automatic logic [63:0] word_of(input logic [15:0] a);
        return {16'hD0D0, a, ~a, a ^ 16'h1234};
    endfunction

    // usram: data valid exactly one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        bus.rd_rdata  <= bus.rd_en  ? word_of(bus.rd_addr)  : 64'hBAD0_BAD0_BAD0_BAD0;
        bus1.rd_rdata <= bus1.rd_en ? word_of(bus1.rd_addr) : 64'hBAD1_BAD1_BAD1_BAD1;
    end

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } sb_t;

    typedef struct packed {
        logic [15:0]       base;
        logic [7:0]        stall;
        logic [3:0][15:0]  exp_addr;
        logic [7:0]        exp_done;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[5];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag, input logic [63:0] d, input logic l);
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected_word: got 0x%0h, want none", tag, d);
        end else begin
            e = sb.pop_front();
            check({tag, " out_data"}, d, e.data);
            check({tag, " out_last"}, 64'(l), 64'(e.last));
        end
    endtask

    function automatic vec_t mkvec(input logic [15:0] base, input logic [7:0] stall,
                                   input logic [15:0] a0, input logic [15:0] a1,
                                   input logic [15:0] a2, input logic [15:0] a3,
                                   input logic [7:0] done_cyc);
        vec_t v;
        v.base        = base;
        v.stall       = stall;
        v.exp_addr[0] = a0;
        v.exp_addr[1] = a1;
        v.exp_addr[2] = a2;
        v.exp_addr[3] = a3;
        v.exp_done    = done_cyc;
        return v;
    endfunction

    // Cycle n counts negedges after the start edge; load_done lands on n = exp_done.
    task automatic run_vec(input vec_t v, input string tag);
        int          rd_idx, fv, done_at, bad;
        logic [63:0] held;
        logic        holding;
        rd_idx = 0; fv = -1; done_at = -1; holding = 1'b0; held = '0;
        @(negedge clk);
        start = 32'd0;
        input_base = {16'h0000, v.base};
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 32'd1;
        for (int i = 0; i < 4; i++) sb.push_back('{data: word_of(v.base + 16'(i)), last: (i == 3)});
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            @(negedge clk);
            if (bus.out_valid && fv < 0) fv = n;
            bus.out_ready = !(fv >= 0 && n < fv + int'(v.stall));
            if (n == 2) input_base = 32'h0000_0200;
            #1;
            if (v.stall != 8'd0 && fv >= 0 && n == fv + int'(v.stall))
                check({tag, " rd_before_release"}, 64'(rd_idx), 64'd2);
            if (bus.rd_en) begin
                if (rd_idx < 4) check({tag, " rd_addr"}, 64'(bus.rd_addr), 64'(v.exp_addr[rd_idx]));
                else check({tag, " extra_rd_en"}, 64'(rd_idx), 64'd3);
                rd_idx++;
            end
            if (holding && bus.out_valid) check({tag, " held_data"}, bus.out_data, held);
            holding = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.out_valid && bus.out_ready) sb_pop_check(tag, bus.out_data, bus.out_last);
            if (load_done) done_at = n;
        end
        check({tag, " load_done_cycle"}, 64'(done_at), 64'(v.exp_done));
        check({tag, " rd_count"}, 64'(rd_idx), 64'd4);
        check({tag, " sb_drained"}, 64'(sb.size()), 64'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (busy || bus.rd_en || load_done || bus.out_valid) bad++;
        end
        check({tag, " no_rerun"}, 64'(bad), 64'd0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rd_en"},     64'(bus.rd_en),     64'd0);
        check({tag, " rd_addr"},   64'(bus.rd_addr),   64'd0);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " out_data"},  bus.out_data,       64'd0);
        check({tag, " out_last"},  64'(bus.out_last),  64'd0);
        check({tag, " busy"},      64'(busy),          64'd0);
        check({tag, " load_done"}, 64'(load_done),     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers, bad, rd_idx, done_at;
        rst_n = 1'b0; start = 32'd0; input_base = 32'd0; start1 = 32'd0; base1 = 32'd0;
        bus.out_ready = 1'b0; bus1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset busy1", 64'(busy1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = mkvec(16'h0100, 8'd0, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 8'd7);
        vecs[1] = mkvec(16'hFFFE, 8'd0, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 8'd7);
        vecs[2] = mkvec(16'h0100, 8'd5, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 8'd12);
        vecs[3] = mkvec(16'h1234, 8'd2, 16'h1234, 16'h1235, 16'h1236, 16'h1237, 8'd9);
        vecs[4] = mkvec(16'h7FFF, 8'd1, 16'h7FFF, 16'h8000, 16'h8001, 16'h8002, 8'd8);
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // abort after two transfers, then a clean restart from word 0
        @(negedge clk);
        start = 32'd0; input_base = 32'h0000_0300; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 32'd1;
        for (int i = 0; i < 4; i++) sb.push_back('{data: word_of(16'h0300 + 16'(i)), last: (i == 3)});
        xfers = 0;
        for (int n = 1; n <= 12 && xfers < 2; n++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                sb_pop_check("abort", bus.out_data, bus.out_last);
                xfers++;
            end
        end
        check("abort xfers", 64'(xfers), 64'd2);
        start = 32'd0;
        @(negedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort rd_en", 64'(bus.rd_en), 64'd0);
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (load_done || busy || bus.out_valid) bad++;
        end
        check("abort no_load_done", 64'(bad), 64'd0);
        sb.delete();
        run_vec(mkvec(16'h0300, 8'd0, 16'h0300, 16'h0301, 16'h0302, 16'h0303, 8'd7), "restart");

        // reset pulse while draining
        @(negedge clk);
        start = 32'd0; input_base = 32'h0000_0400; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 32'd1;
        for (int i = 0; i < 4; i++) sb.push_back('{data: word_of(16'h0400 + 16'(i)), last: (i == 3)});
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid && bus.out_ready) sb_pop_check("drain", bus.out_data, bus.out_last);
        end
        check("drain state", 64'(busy && !bus.rd_en && !load_done), 64'd1);
        rst_n = 1'b0;
        start = 32'd0;
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (load_done || busy || bus.out_valid || bus.rd_en) bad++;
        end
        check("midreset quiet", 64'(bad), 64'd0);
        sb.delete();

        // single-word configuration
        @(negedge clk);
        start1 = 32'd0; base1 = 32'h0000_0050; bus1.out_ready = 1'b1;
        @(negedge clk);
        start1 = 32'd1;
        sb.push_back('{data: word_of(16'h0050), last: 1'b1});
        rd_idx = 0; done_at = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            #1;
            if (bus1.rd_en) begin
                check("nw1 rd_addr", 64'(bus1.rd_addr), 64'h0050);
                rd_idx++;
            end
            if (bus1.out_valid && bus1.out_ready) sb_pop_check("nw1", bus1.out_data, bus1.out_last);
            if (load_done1 && done_at < 0) done_at = n;
        end
        check("nw1 rd_count", 64'(rd_idx), 64'd1);
        check("nw1 load_done_cycle", 64'(done_at), 64'd4);
        check("nw1 sb_drained", 64'(sb.size()), 64'd0);
        start1 = 32'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
